// File: rtl/intersection_control.sv
// Multi-phase intersection controller: round-robin vehicle greens with all-red
// clearance, an exclusive pedestrian walk phase and demand-actuated skipping.

module intersection_lamp (
    input  logic       sel,
    input  logic       green,
    input  logic       yellow,
    output logic [1:0] light
);
    always_comb begin
        light = 2'b00;
        if (sel && green)       light = 2'b01;
        else if (sel && yellow) light = 2'b10;
    end
endmodule

module intersection_control #(
    parameter int C_PHASES        = 4,
    parameter int C_TW            = 8,
    parameter int C_INT_GREEN     = 200,
    parameter int C_INT_GREEN_MIN = 50,
    parameter int C_INT_YELLOW    = 20,
    parameter int C_INT_CLEAR     = 10,
    parameter int C_INT_WALK      = 100,
    localparam int PW             = (C_PHASES > 2) ? $clog2(C_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  inMode,
    input  logic [C_PHASES-1:0]   inTraffic,
    input  logic                  inPedestrian,
    output logic [2*C_PHASES-1:0] outLight,
    output logic                  outWalk,
    output logic [PW-1:0]         outPhase,
    output logic                  outPedLatch
);
    localparam logic [C_TW-1:0] T_GREEN     = C_TW'(C_INT_GREEN);
    localparam logic [C_TW-1:0] T_GREEN_MIN = C_TW'(C_INT_GREEN_MIN);
    localparam logic [C_TW-1:0] T_YELLOW    = C_TW'(C_INT_YELLOW);
    localparam logic [C_TW-1:0] T_CLEAR     = C_TW'(C_INT_CLEAR);
    localparam logic [C_TW-1:0] T_WALK      = C_TW'(C_INT_WALK);
    localparam logic [PW-1:0]   LAST_PHASE  = PW'(C_PHASES - 1);

    typedef enum logic [1:0] {sClear, sGreen, sYellow, sWalk} state_t;

    state_t          state, nextState;
    logic [PW-1:0]   rPhase, nextPhase, pickPhase;
    logic [C_TW-1:0] timer;
    logic            rPedLatch, rAfterWalk;
    logic            otherDemand, stateChange;

    // Candidate for the next green. The second loop overrides the first, so a
    // demanding phase above rPhase wins over one that needs a wrap-around.
    always_comb begin
        pickPhase = (rPhase >= LAST_PHASE) ? '0 : rPhase + PW'(1);
        if (inMode) begin
            for (int p = C_PHASES - 1; p >= 0; p--)
                if (inTraffic[p] && PW'(p) <= rPhase) pickPhase = PW'(p);
            for (int p = C_PHASES - 1; p >= 0; p--)
                if (inTraffic[p] && PW'(p) > rPhase) pickPhase = PW'(p);
        end
    end

    always_comb begin
        otherDemand = 1'b0;
        for (int p = 0; p < C_PHASES; p++)
            if (inTraffic[p] && PW'(p) != rPhase) otherDemand = 1'b1;
    end

    always_comb begin
        nextState = state;
        nextPhase = rPhase;
        case (state)
            sClear:
                if (timer >= T_CLEAR) begin
                    if (rPedLatch && !rAfterWalk) begin
                        nextState = sWalk;
                    end else begin
                        nextState = sGreen;
                        nextPhase = pickPhase;
                    end
                end
            sGreen:
                if (timer >= T_GREEN ||
                    (inMode && (rPedLatch || otherDemand) && timer >= T_GREEN_MIN))
                    nextState = sYellow;
            sYellow:
                if (timer >= T_YELLOW) nextState = sClear;
            sWalk:
                if (timer >= T_WALK) nextState = sClear;
            default:
                nextState = sClear;
        endcase
    end

    assign stateChange = (nextState != state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= sClear;
            rPhase     <= LAST_PHASE;
            timer      <= '0;
            rPedLatch  <= 1'b0;
            rAfterWalk <= 1'b0;
        end else begin
            state  <= nextState;
            rPhase <= nextPhase;
            // A tick on the edge of a state change is dropped; timer saturates.
            if (stateChange)
                timer <= '0;
            else if (tick && timer != '1)
                timer <= timer + C_TW'(1);
            rPedLatch <= (nextState == sWalk) ? 1'b0 : (rPedLatch | inPedestrian);
            if (state == sWalk && stateChange)
                rAfterWalk <= 1'b1;
            else if (nextState == sGreen && stateChange)
                rAfterWalk <= 1'b0;
        end
    end

    assign outWalk     = (state == sWalk);
    assign outPhase    = rPhase;
    assign outPedLatch = rPedLatch;

    for (genvar g = 0; g < C_PHASES; g++) begin : gLamp
        intersection_lamp uLamp (
            .sel    (rPhase == PW'(g)),
            .green  (state == sGreen),
            .yellow (state == sYellow),
            .light  (outLight[2*g+1:2*g])
        );
    end
endmodule

// File: tb/tb_intersection_control.sv
// Randomized bench for intersection_control against an interval-level model
// of the controller (kind of interval, ticks elapsed, served phase, requests).

module tb_intersection_control;
    localparam int P = 3, GREEN = 8, GMIN = 3, YELLOW = 2, CLEAR = 1, WALK = 4;
    localparam int K_CLEAR = 0, K_GREEN = 1, K_YELLOW = 2, K_WALK = 3;

    logic         clk = 1'b0;
    logic         rst, tick, inMode, inPedestrian;
    logic [P-1:0] inTraffic;
    logic [5:0]   outLight;
    logic         outWalk, outPedLatch;
    logic [1:0]   outPhase;

    int nChecks = 0, nFails = 0, tickDiv = 0;
    int mKind, mPhase, mTicks;
    bit mLatch, mAfterWalk;

    intersection_control #(
        .C_PHASES(P), .C_TW(8), .C_INT_GREEN(GREEN), .C_INT_GREEN_MIN(GMIN),
        .C_INT_YELLOW(YELLOW), .C_INT_CLEAR(CLEAR), .C_INT_WALK(WALK)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .inMode(inMode), .inTraffic(inTraffic),
        .inPedestrian(inPedestrian), .outLight(outLight), .outWalk(outWalk),
        .outPhase(outPhase), .outPedLatch(outPedLatch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic mReset();
        mKind = K_CLEAR; mPhase = P - 1; mTicks = 0; mLatch = 0; mAfterWalk = 0;
    endtask

    function automatic int dwell(input int kind, input bit mode, input logic [P-1:0] traf);
        logic [P-1:0] others;
        others = traf & ~(P'(1) << mPhase);
        case (kind)
            K_CLEAR:  return CLEAR;
            K_GREEN:  return (mode && (mLatch || others != 0)) ? GMIN : GREEN;
            K_YELLOW: return YELLOW;
            default:  return WALK;
        endcase
    endfunction

    // Next phase to serve: cyclic search for demand in actuated mode.
    function automatic int nextServed(input bit mode, input logic [P-1:0] traf);
        if (mode)
            for (int k = 1; k <= P; k++) begin
                int q = (mPhase + k) % P;
                if (((traf >> q) & P'(1)) != 0) return q;
            end
        return (mPhase + 1) % P;
    endfunction

    // Advance the model across one rising edge with the given inputs.
    task automatic modelStep(input bit r, input bit t, input bit mode,
                             input logic [P-1:0] traf, input bit ped);
        int nk, np;
        if (r) begin mReset(); return; end
        nk = mKind; np = mPhase;
        if (mTicks >= dwell(mKind, mode, traf)) begin
            if (mKind == K_CLEAR) begin
                if (mLatch && !mAfterWalk) nk = K_WALK;
                else begin nk = K_GREEN; np = nextServed(mode, traf); end
            end else if (mKind == K_GREEN) nk = K_YELLOW;
            else nk = K_CLEAR;
        end
        mLatch = (nk == K_WALK) ? 1'b0 : (mLatch | ped);
        if (mKind == K_WALK && nk != K_WALK) mAfterWalk = 1;
        if (mKind != K_GREEN && nk == K_GREEN) mAfterWalk = 0;
        mTicks = (nk != mKind) ? 0 : mTicks + int'(t);
        mKind = nk; mPhase = np;
    endtask

    task automatic compareAll();
        logic [5:0] expLight;
        expLight = '0;
        if (mKind == K_GREEN)  expLight = 6'd1 << (2 * mPhase);
        if (mKind == K_YELLOW) expLight = 6'd2 << (2 * mPhase);
        chk("light", 32'(outLight), 32'(expLight));
        chk("walk", 32'(outWalk), 32'(mKind == K_WALK));
        chk("phase", 32'(outPhase), 32'(mPhase));
        chk("pedLatch", 32'(outPedLatch), 32'(mLatch));
    endtask

    // One clock: check on the falling edge, then apply inputs for the next rise.
    task automatic cycle(input bit r, input bit mode, input logic [P-1:0] traf,
                         input bit ped, input bit randTick);
        @(negedge clk);
        compareAll();
        if (randTick) tick = ($urandom_range(2, 0) == 0);
        else          tick = (tickDiv == 3);
        tickDiv = (tickDiv + 1) % 4;
        rst = r; inMode = mode; inTraffic = traf; inPedestrian = ped;
        modelStep(r, tick, mode, traf, ped);
    endtask

    task automatic waitKind(input int kind, input int phase, input bit mode,
                            input logic [P-1:0] traf, input bit ped);
        int n = 0;
        while (!(mKind == kind && (phase < 0 || mPhase == phase)) && n < 800) begin
            cycle(0, mode, traf, ped, 0);
            n++;
        end
        chk("reachKind", 32'(mKind), 32'(kind));
    endtask

    initial begin
        bit           sMode, sPed;
        logic [P-1:0] sTraf;
        rst = 1; tick = 0; inMode = 0; inTraffic = '0; inPedestrian = 0;
        mReset();
        #1;
        chk("rstLight", 32'(outLight), 32'd0);
        chk("rstWalk", 32'(outWalk), 32'd0);
        chk("rstPhase", 32'(outPhase), 32'd2);
        chk("rstLatch", 32'(outPedLatch), 32'd0);
        repeat (3) cycle(1, 0, '0, 0, 0);

        // Fixed-time rotation, no requests.
        repeat (300) cycle(0, 0, '0, 0, 0);
        // Pedestrian press during green1.
        waitKind(K_GREEN, 1, 0, '0, 0);
        repeat (3) cycle(0, 0, '0, 0, 0);
        cycle(0, 0, '0, 1, 0);
        repeat (200) cycle(0, 0, '0, 0, 0);
        // Actuated: demand only on phase 2 during green0, then no demand.
        waitKind(K_GREEN, 0, 1, '0, 0);
        repeat (150) cycle(0, 1, 3'b100, 0, 0);
        repeat (150) cycle(0, 1, 3'b000, 0, 0);

        // Asynchronous reset in the middle of a walk with the button held.
        waitKind(K_WALK, -1, 0, '0, 1);
        repeat (3) cycle(0, 0, '0, 1, 0);
        @(posedge clk);
        #1 rst = 1;
        #1;
        chk("asyncLight", 32'(outLight), 32'd0);
        chk("asyncWalk", 32'(outWalk), 32'd0);
        chk("asyncLatch", 32'(outPedLatch), 32'd0);
        chk("asyncPhase", 32'(outPhase), 32'd2);
        mReset();
        repeat (3) cycle(1, 0, '0, 1, 0);

        // Button held through walks; fixed then random tick placement.
        repeat (400) cycle(0, 0, '0, 1, 0);
        repeat (400) cycle(0, 1, 3'b011, 1, 1);

        sMode = 0; sTraf = '0; sPed = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(199, 0) == 0) sMode = ~sMode;
            if ($urandom_range(19, 0) == 0) sTraf = P'($urandom);
            sPed = ($urandom_range(29, 0) == 0);
            cycle(0, sMode, sTraf, sPed, 1);
        end
        cycle(0, sMode, sTraf, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
